mem_access_unit: RTL and testbench

//  Memory-stage load/store engine downstream of the execute->memory pipeline register.

---
 rtl/mem_access_unit_if.sv | 27 ++
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory-stage load/store engine and memory.
//   mem_req   : request, held high for the whole transfer
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word address (low two bits always zero)
//   mem_wdata : write data, already lane-replicated for byte stores
//   mem_be    : byte enables
//   mem_ready : memory completes the transfer this cycle
//   mem_rdata : read data, valid while mem_ready=1
// master = load/store engine, slave = memory.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine.
// Takes the M-stage address, store data and access controls. It runs one
// transfer on a variable-latency req/ready bus and returns the aligned,
// lane-selected load result. StallM freezes the pipeline while a transfer
// is in flight.
// Ports:
//   clk, reset          : clock; asynchronous active-high reset
//   MemReadM/MemWriteM  : load / store in M (the store wins if both are high)
//   MByteM              : 1 = byte access, 0 = word access
//   ALUOutM, WriteDataM : byte address, store data
//   bus (master)        : data-memory bus, see mem_access_unit_if
//   ReadDataM           : load result, held until the next load completes
//   StallM              : pipeline freeze
//   Misaligned          : one-cycle pulse for a word access with addr[1:0]!=0
//   MemFault            : sticky bus-timeout flag
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY transfer after
// TIMEOUT_CYCLES cycles without mem_ready. Without it, MemFault is tied 0.
module mem_access_unit #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] FAULT_DATA     = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemReadM,
  input  logic                MemWriteM,
  input  logic                MByteM,
  input  logic [31:0]         ALUOutM,
  input  logic [31:0]         WriteDataM,
  mem_access_unit_if.master   bus,
  output logic [31:0]         ReadDataM,
  output logic                StallM,
  output logic                Misaligned,
  output logic                MemFault
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic        load_q, load_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;

  logic        access;
  logic [63:0] rd_dbl;
  logic [31:0] rd_fmt;

`ifdef MEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
`endif

  assign access = MemReadM | MemWriteM;

  // A word load rotates right by the byte offset. The lane for a byte load
  // lands in bits [7:0] of the same rotation.
  assign rd_dbl = {bus.mem_rdata, bus.mem_rdata} >> {lo_q, 3'b000};
  assign rd_fmt = byte_q ? {24'h0, rd_dbl[7:0]} : rd_dbl[31:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    byte_d  = byte_q;
    load_d  = load_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    fault_d = fault_q;
`endif
    case (state_q)
      IDLE: if (access) begin
        state_d = BUSY;
        addr_d  = {ALUOutM[31:2], 2'b00};
        lo_d    = ALUOutM[1:0];
        we_d    = MemWriteM;
        load_d  = MemReadM & ~MemWriteM;
        byte_d  = MByteM;
        be_d    = MByteM ? (4'b0001 << ALUOutM[1:0]) : 4'b1111;
        wdata_d = MByteM ? {4{WriteDataM[7:0]}} : WriteDataM;
        mis_d   = ~MByteM & (|ALUOutM[1:0]);
`ifdef MEM_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      BUSY: begin
        if (bus.mem_ready) begin
          state_d = DONE;
          if (load_q) rdata_d = rd_fmt;
        end
`ifdef MEM_TIMEOUT_EN
        // Count the current idle cycle as well, so the abort comes after
        // exactly TIMEOUT_CYCLES BUSY cycles.
        else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          fault_d = 1'b1;
          if (load_q) rdata_d = FAULT_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      // An access seen in DONE is the instruction that just finished.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      lo_q    <= 2'b00;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      load_q  <= 1'b0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      load_q  <= load_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 8'h0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  assign MemFault = fault_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, FAULT_DATA};
  assign MemFault   = 1'b0;
`endif

  // Gating with reset stops the still-asserted M-stage controls from
  // raising a stall while the pipeline is being reset.
  assign StallM        = ~reset & (((state_q == IDLE) & access) | (state_q == BUSY));
  assign bus.mem_req   = (state_q == BUSY);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign ReadDataM     = rdata_q;
  assign Misaligned    = mis_q;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM, MByteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, Misaligned, MemFault;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT_CYCLES(4), .FAULT_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MByteM(MByteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .bus(bus.master),
    .ReadDataM(ReadDataM), .StallM(StallM),
    .Misaligned(Misaligned), .MemFault(MemFault)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // observations from the last transfer
  int          o_stall, o_busy, o_mis;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;
  logic        o_we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge with the unit in IDLE. Acts as the
  // memory: mem_ready is raised after `waits` BUSY cycles. Returns at the
  // falling edge of the DONE cycle with the controls still applied.
  task automatic run_access(input logic rd, input logic wr, input logic mb,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int waits, input logic [31:0] rdat);
    int w;
    bit done;
    w = 0; done = 0;
    o_stall = 0; o_busy = 0; o_mis = 0;
    o_addr = 'x; o_wdata = 'x; o_be = 'x; o_we = 'x;
    MemReadM = rd; MemWriteM = wr; MByteM = mb; ALUOutM = addr; WriteDataM = wd;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      if (Misaligned) o_mis++;
      if (!StallM) done = 1;
      else begin
        o_stall++;
        if (bus.mem_req) begin
          o_busy++;
          o_addr = bus.mem_addr; o_wdata = bus.mem_wdata;
          o_be = bus.mem_be; o_we = bus.mem_we;
          if (w == waits) begin
            bus.mem_ready = 1'b1; bus.mem_rdata = rdat;
          end else w++;
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
      end
    end
    if (!done) check("done_timeout", 32'(o_stall), 32'd0);
  endtask

  task automatic finish_access();
    MemReadM = 0; MemWriteM = 0; MByteM = 0; ALUOutM = 0; WriteDataM = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    MemReadM = 0; MemWriteM = 0; MByteM = 0; ALUOutM = 0; WriteDataM = 0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req",   32'(bus.mem_req), 32'd0);
    check("rst_we",    32'(bus.mem_we), 32'd0);
    check("rst_be",    32'(bus.mem_be), 32'd0);
    check("rst_addr",  bus.mem_addr, 32'h0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_rdata", ReadDataM, 32'h0);
    check("rst_stall", 32'(StallM), 32'd0);
    check("rst_mis",   32'(Misaligned), 32'd0);
    check("rst_fault", 32'(MemFault), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // idle: nothing happens
    repeat (2) begin
      @(negedge clk);
      check("idle_stall", 32'(StallM), 32'd0);
      check("idle_req",   32'(bus.mem_req), 32'd0);
    end
    @(posedge clk); #1;

    // LDR 0x100, two wait cycles
    run_access(1, 0, 0, 32'h100, 32'h0, 2, 32'h11223344);
    check("ldr_stall", 32'(o_stall), 32'd4);
    check("ldr_busy",  32'(o_busy), 32'd3);
    check("ldr_addr",  o_addr, 32'h100);
    check("ldr_be",    32'(o_be), 32'hF);
    check("ldr_we",    32'(o_we), 32'd0);
    check("ldr_mis",   32'(o_mis), 32'd0);
    check("ldr_data",  ReadDataM, 32'h11223344);
    check("ldr_req_done", 32'(bus.mem_req), 32'd0);
    finish_access();

    // STRB 0x203, no wait
    run_access(0, 1, 1, 32'h203, 32'h000000AB, 0, 32'h0);
    check("strb_stall", 32'(o_stall), 32'd2);
    check("strb_addr",  o_addr, 32'h200);
    check("strb_be",    32'(o_be), 32'h8);
    check("strb_wdata", o_wdata, 32'hABABABAB);
    check("strb_we",    32'(o_we), 32'd1);
    check("strb_keep",  ReadDataM, 32'h11223344);
    finish_access();

    // LDRB 0x302
    run_access(1, 0, 1, 32'h302, 32'h0, 1, 32'hA1B2C3D4);
    check("ldrb_addr", o_addr, 32'h300);
    check("ldrb_data", ReadDataM, 32'h000000B2);
    check("ldrb_mis",  32'(o_mis), 32'd0);
    finish_access();

    // LDR 0x401 misaligned: rotate, one-cycle pulse
    run_access(1, 0, 0, 32'h401, 32'h0, 0, 32'h11223344);
    check("ldrm_addr", o_addr, 32'h400);
    check("ldrm_data", ReadDataM, 32'h44112233);
    check("ldrm_mis",  32'(o_mis), 32'd1);
    finish_access();

    // read and write both high: write wins, ReadDataM untouched
    run_access(1, 1, 0, 32'h500, 32'hCAFEF00D, 0, 32'h99999999);
    check("rw_we",    32'(o_we), 32'd1);
    check("rw_wdata", o_wdata, 32'hCAFEF00D);
    check("rw_be",    32'(o_be), 32'hF);
    check("rw_keep",  ReadDataM, 32'h44112233);
    finish_access();
    @(negedge clk);
    check("after_stall", 32'(StallM), 32'd0);
    check("fault_off",   32'(MemFault), 32'd0);
    @(posedge clk); #1;

    // reset during the second BUSY cycle
    MemReadM = 1; ALUOutM = 32'h600;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_req_pre", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_req",   32'(bus.mem_req), 32'd0);
    check("mid_stall", 32'(StallM), 32'd0);
    MemReadM = 0; ALUOutM = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_stall", 32'(StallM), 32'd0);
    check("post_req",   32'(bus.mem_req), 32'd0);
    check("post_data",  ReadDataM, 32'h0);
    @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
    // memory never answers: abort after 4 BUSY cycles
    run_access(1, 0, 0, 32'h700, 32'h0, 1000, 32'h0);
    check("to_busy",  32'(o_busy), 32'd4);
    check("to_data",  ReadDataM, 32'hDEADBEEF);
    check("to_fault", 32'(MemFault), 32'd1);
    finish_access();
    run_access(0, 1, 0, 32'h704, 32'h1, 0, 32'h0);
    check("to_sticky", 32'(MemFault), 32'd1);
    finish_access();
    reset = 1'b1;
    #1;
    check("to_clear", 32'(MemFault), 32'd0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
